i2c_apb_regif: RTL and testbench
================================

// Module: i2c_apb_regif
// PURPOSE
// - APB3 slave register front-end that sits directly upstream of the I2C byte controller.
// - Holds target address, mode and control bits, and a TX byte FIFO; drives the controller's
//   enable/slave_address/data_in/rw/repeated_start_cond inputs.
// - Captures received bytes and status back from the controller for CPU readback.
// PARAMETERS
// - ADDR_W      5  APB address width (byte address; PADDR[4:2] decoded)
// - FIFO_DEPTH  4  TX FIFO entries; power of 2, >=2
// PORTS
// - clk                  in   1  clock (APB and controller share it)
// - rst_n                in   1  reset, asynchronous, active-low
// - psel,penable,pwrite  in   1  APB3 control
// - paddr                in   ADDR_W  APB byte address
// - pwdata               in   32 APB write data
// - prdata               out  32 APB read data
// - pready               out  1  tied 1 (zero-wait)
// - pslverr              out  1  error response, valid in access phase
// - i2c_enable           out  1  to controller enable
// - i2c_slave_address    out  7  ADDR[6:0]
// - i2c_rw               out  1  1=write, 0=read (controller encoding)
// - i2c_repeated_start   out  1  CTRL.RSTART
// - i2c_data_in          out  8  TX FIFO head (0 when empty)
// - i2c_byte_done        in   1  1-cycle pulse: byte transferred (write: pop head)
// - i2c_rx_data          in   8  received byte, valid with i2c_rx_valid
// - i2c_rx_valid         in   1  1-cycle pulse
// - i2c_nack             in   1  1-cycle pulse: slave NACK
// - i2c_busy             in   1  controller not in IDLE
// - irq                  out  1  (RXV&IE_RX)|(TXEMPTY&IE_TX)|NACK|OVR
// BEHAVIOUR
// - Reset: all regs 0, FIFO empty, FSM IDLE; prdata=0, pslverr=0, i2c_enable=0, irq=0.
// - APB: write commits on psel&penable&pwrite; read data driven combinationally in access phase.
// - Map: 0x00 CTRL [0]EN [1]RW [2]RSTART [3]FLUSH(self-clear, reads 0) [4]IE_RX [5]IE_TX;
//   0x04 ADDR[6:0]; 0x08 TXDATA (write=push, read=0); 0x0C RXDATA (read clears RXV);
//   0x10 STATUS [0]TXEMPTY [1]TXFULL [2]RXV [3]BUSY [4]NACK [5]OVR; [4],[5] sticky W1C.
// - pslverr=1: paddr>0x10, or TXDATA write while full (data dropped, OVR set).
// - RX: i2c_rx_valid loads RXDATA and sets RXV; if RXV already set, also set OVR (new byte kept).
// - FIFO: push+pop same cycle when full -> both succeed, count unchanged, no OVR.
//   Pop when empty ignored. FLUSH empties FIFO next cycle; FLUSH wins over same-cycle push.
// - FSM: IDLE -> RUN when EN & (RW=0 | !TXEMPTY).
//   RUN: i2c_enable=1; on i2c_byte_done & RW=1 pop.
//   RUN -> STOPW when EN=0, NACK pulse, or (RW=1 & FIFO empty after pop).
//   STOPW: i2c_enable=0; -> IDLE when i2c_busy=0.
//   Writes to ADDR/RW in RUN are accepted but take effect only from the next IDLE->RUN
//   (shadow latched on entry to RUN).
// - NACK pulse: sets STATUS.NACK, clears CTRL.EN.
// - Latency: CTRL.EN write -> i2c_enable high 1 cycle after commit cycle (registered).
// - Reset mid-transfer: outputs drop immediately (async); controller reset separately.
// STRUCTURE
// - Shared package/include i2c_pkg: register offsets, CTRL/STATUS bit indices, FSM encodings.
// - Sub-module i2c_tx_fifo (sync FIFO, DEPTH/WIDTH params, push/pop/flush, full/empty/count).
// - Top: APB decode, register bank, RX capture, 3-state FSM.
// TESTING
// - Reset: read all regs -> 0 except STATUS=0x01; pready=1, i2c_enable=0.
// - Write ADDR=0x6B, push 0xAA,0x55, CTRL=0x03 -> i2c_enable=1, rw=1, addr=0x6B, data_in=0xAA;
//   byte_done -> 0x55; byte_done -> FIFO empty, enable=0, IDLE after busy=0.
// - Push 5 bytes (depth 4) -> 5th: pslverr=1, OVR=1, FIFO holds first 4;
//   W1C STATUS 0x20 -> OVR=0.
// - Read mode CTRL=0x01: two rx_valid (0x11,0x22) without reading -> RXDATA=0x22, OVR=1;
//   read RXDATA -> RXV=0.
// - NACK pulse in RUN -> EN=0, NACK=1, enable=0 next cycle, irq=1.
// - Full FIFO, simultaneous byte_done pop + APB push -> no error, count stays 4, order preserved.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C APB register front-end: register word offsets,
// CTRL/STATUS bit positions and FSM state encodings.
package i2c_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_ADDR   = 3'd1;
    localparam logic [2:0] REG_TXDATA = 3'd2;
    localparam logic [2:0] REG_RXDATA = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_RW     = 1;
    localparam int CTRL_RSTART = 2;
    localparam int CTRL_FLUSH  = 3;
    localparam int CTRL_IE_RX  = 4;
    localparam int CTRL_IE_TX  = 5;

    localparam int ST_NACK = 4;
    localparam int ST_OVR  = 5;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STOPW = 2'd2;

endpackage

// File: rtl/i2c_tx_fifo.sv
// Synchronous TX byte FIFO with flush; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module i2c_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == CW'(0));
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/i2c_apb_regif.sv
// APB3 register front-end for the I2C byte controller: register bank, TX FIFO,
// RX capture and the IDLE/RUN/STOPW sequencing FSM.
module i2c_apb_regif
    import i2c_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              i2c_enable,
    output logic [6:0]        i2c_slave_address,
    output logic              i2c_rw,
    output logic              i2c_repeated_start,
    output logic [7:0]        i2c_data_in,
    input  logic              i2c_byte_done,
    input  logic [7:0]        i2c_rx_data,
    input  logic              i2c_rx_valid,
    input  logic              i2c_nack,
    input  logic              i2c_busy,
    output logic              irq
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             wr_en, rd_en, addr_err;
    logic [2:0]       reg_sel;
    logic             ctrl_en, ctrl_rw, ctrl_rstart, ie_rx, ie_tx;
    logic [6:0]       addr_reg, addr_sh;
    logic             rw_sh;
    logic [7:0]       rx_data;
    logic             rxv, nack_st, ovr;
    logic [1:0]       state;
    logic             tx_wr, tx_ovf, push, pop, flush;
    logic             tx_full, tx_empty;
    logic [7:0]       tx_head;
    logic [CNT_W-1:0] tx_count;
    logic             unused_wdata;

    assign unused_wdata = ^pwdata[31:8];

    assign wr_en    = psel & penable & pwrite;
    assign rd_en    = psel & penable & ~pwrite;
    assign reg_sel  = paddr[4:2];
    assign addr_err = (paddr > ADDR_W'(16));

    // Pops only happen for write transfers while running; a full FIFO still takes a push
    // when the controller frees a slot in the same cycle.
    assign pop     = (state == S_RUN) & i2c_byte_done & rw_sh & ~tx_empty;
    assign flush   = wr_en & ~addr_err & (reg_sel == REG_CTRL) & pwdata[CTRL_FLUSH];
    assign tx_wr   = wr_en & ~addr_err & (reg_sel == REG_TXDATA);
    assign tx_ovf  = tx_wr & tx_full & ~pop;
    assign push    = tx_wr & ~tx_ovf & ~flush;
    assign pready  = 1'b1;
    assign pslverr = psel & penable & (addr_err | tx_ovf);

    i2c_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (pwdata[7:0]),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en     <= 1'b0;
            ctrl_rw     <= 1'b0;
            ctrl_rstart <= 1'b0;
            ie_rx       <= 1'b0;
            ie_tx       <= 1'b0;
            addr_reg    <= '0;
            rx_data     <= '0;
            rxv         <= 1'b0;
            nack_st     <= 1'b0;
            ovr         <= 1'b0;
        end else begin
            if (wr_en && !addr_err) begin
                case (reg_sel)
                    REG_CTRL: begin
                        ctrl_en     <= pwdata[CTRL_EN];
                        ctrl_rw     <= pwdata[CTRL_RW];
                        ctrl_rstart <= pwdata[CTRL_RSTART];
                        ie_rx       <= pwdata[CTRL_IE_RX];
                        ie_tx       <= pwdata[CTRL_IE_TX];
                    end
                    REG_ADDR: addr_reg <= pwdata[6:0];
                    default: ;
                endcase
            end
            if (i2c_nack) ctrl_en <= 1'b0;

            // A new byte always wins over a same-cycle read-clear of RXV.
            if (i2c_rx_valid) begin
                rx_data <= i2c_rx_data;
                rxv     <= 1'b1;
            end else if (rd_en && !addr_err && reg_sel == REG_RXDATA) begin
                rxv <= 1'b0;
            end

            if (i2c_nack)
                nack_st <= 1'b1;
            else if (wr_en && !addr_err && reg_sel == REG_STATUS && pwdata[ST_NACK])
                nack_st <= 1'b0;

            if ((i2c_rx_valid && rxv) || tx_ovf)
                ovr <= 1'b1;
            else if (wr_en && !addr_err && reg_sel == REG_STATUS && pwdata[ST_OVR])
                ovr <= 1'b0;
        end
    end

    // Address and direction are sampled on IDLE->RUN so CPU writes mid-transfer are deferred.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            rw_sh   <= 1'b0;
            addr_sh <= '0;
        end else begin
            case (state)
                S_IDLE: if (ctrl_en && (!ctrl_rw || !tx_empty)) begin
                    state   <= S_RUN;
                    rw_sh   <= ctrl_rw;
                    addr_sh <= addr_reg;
                end
                S_RUN: if (!ctrl_en || i2c_nack ||
                           (rw_sh && (tx_empty || (pop && !push && tx_count == CNT_W'(1)))))
                    state <= S_STOPW;
                S_STOPW: if (!i2c_busy) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign i2c_enable         = (state == S_RUN);
    assign i2c_slave_address  = addr_sh;
    assign i2c_rw             = rw_sh;
    assign i2c_repeated_start = ctrl_rstart;
    assign i2c_data_in        = tx_empty ? 8'h00 : tx_head;
    assign irq = (rxv & ie_rx) | (tx_empty & ie_tx) | nack_st | ovr;

    always_comb begin
        prdata = '0;
        if (rd_en && !addr_err) begin
            case (reg_sel)
                REG_CTRL:   prdata = {26'd0, ie_tx, ie_rx, 1'b0, ctrl_rstart, ctrl_rw, ctrl_en};
                REG_ADDR:   prdata = {25'd0, addr_reg};
                REG_RXDATA: prdata = {24'd0, rx_data};
                REG_STATUS: prdata = {26'd0, ovr, nack_st, i2c_busy, rxv, tx_full, tx_empty};
                default:    prdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_apb_regif.sv
// Directed bench for i2c_apb_regif: register table vectors followed by hand-written
// transfer, overflow, RX, NACK, full-FIFO push/pop and async reset sequences.
module tb_i2c_apb_regif;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [4:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic        i2c_enable, i2c_rw, i2c_repeated_start;
    logic [6:0]  i2c_slave_address;
    logic [7:0]  i2c_data_in;
    logic        i2c_byte_done = 1'b0;
    logic [7:0]  i2c_rx_data = '0;
    logic        i2c_rx_valid = 1'b0;
    logic        i2c_nack = 1'b0;
    logic        i2c_busy = 1'b0;
    logic        irq;

    int checks = 0;
    int failures = 0;

    i2c_apb_regif #(.ADDR_W(5), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr),
        .i2c_enable(i2c_enable), .i2c_slave_address(i2c_slave_address),
        .i2c_rw(i2c_rw), .i2c_repeated_start(i2c_repeated_start),
        .i2c_data_in(i2c_data_in), .i2c_byte_done(i2c_byte_done),
        .i2c_rx_data(i2c_rx_data), .i2c_rx_valid(i2c_rx_valid),
        .i2c_nack(i2c_nack), .i2c_busy(i2c_busy), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Two-cycle APB access; returns just after the commit edge.
    task automatic apb(input logic wr, input logic [4:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic err);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1; #1;
        rd  = prdata;
        err = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr_chk(input string name, input logic [4:0] a, input logic [31:0] d,
                          input logic exp_err);
        logic [31:0] rd;
        logic        err;
        apb(1'b1, a, d, rd, err);
        check({name, "_err"}, {31'd0, err}, {31'd0, exp_err});
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic        err;
        apb(1'b0, a, 32'd0, rd, err);
        check(name, rd, exp);
    endtask

    task automatic pulse_byte_done();
        i2c_byte_done = 1'b1;
        @(posedge clk); #1;
        i2c_byte_done = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;

        vecs[0]  = '{1'b0, 5'h00, 32'h0,  32'h00, 1'b0};
        vecs[1]  = '{1'b0, 5'h04, 32'h0,  32'h00, 1'b0};
        vecs[2]  = '{1'b0, 5'h08, 32'h0,  32'h00, 1'b0};
        vecs[3]  = '{1'b0, 5'h0C, 32'h0,  32'h00, 1'b0};
        vecs[4]  = '{1'b0, 5'h10, 32'h0,  32'h01, 1'b0};
        vecs[5]  = '{1'b0, 5'h14, 32'h0,  32'h00, 1'b1};
        vecs[6]  = '{1'b1, 5'h04, 32'hFF, 32'h00, 1'b0};
        vecs[7]  = '{1'b0, 5'h04, 32'h0,  32'h7F, 1'b0};
        vecs[8]  = '{1'b1, 5'h00, 32'h3C, 32'h00, 1'b0};
        vecs[9]  = '{1'b0, 5'h00, 32'h0,  32'h34, 1'b0};
        vecs[10] = '{1'b1, 5'h00, 32'h00, 32'h00, 1'b0};
        vecs[11] = '{1'b1, 5'h1C, 32'h00, 32'h00, 1'b1};
        vecs[12] = '{1'b0, 5'h00, 32'h0,  32'h00, 1'b0};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        check("rst_pready", {31'd0, pready}, 32'd1);
        check("rst_enable", {31'd0, i2c_enable}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);

        for (int i = 0; i < 13; i++) begin
            apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err);
            if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
        end

        // Write transfer of two bytes
        wr_chk("a_addr", 5'h04, 32'h6B, 1'b0);
        wr_chk("a_push0", 5'h08, 32'hAA, 1'b0);
        wr_chk("a_push1", 5'h08, 32'h55, 1'b0);
        rd_chk("a_status_pre", 5'h10, 32'h00);
        wr_chk("a_ctrl", 5'h00, 32'h03, 1'b0);
        check("a_enable_commit", {31'd0, i2c_enable}, 32'd0);
        @(posedge clk); #1;
        check("a_enable", {31'd0, i2c_enable}, 32'd1);
        check("a_rw", {31'd0, i2c_rw}, 32'd1);
        check("a_slave_addr", {25'd0, i2c_slave_address}, 32'h6B);
        check("a_data0", {24'd0, i2c_data_in}, 32'hAA);
        i2c_busy = 1'b1;
        pulse_byte_done();
        check("a_data1", {24'd0, i2c_data_in}, 32'h55);
        check("a_enable_mid", {31'd0, i2c_enable}, 32'd1);
        wr_chk("a_addr_run", 5'h04, 32'h12, 1'b0);
        check("a_addr_shadow", {25'd0, i2c_slave_address}, 32'h6B);
        pulse_byte_done();
        check("a_enable_done", {31'd0, i2c_enable}, 32'd0);
        check("a_data_empty", {24'd0, i2c_data_in}, 32'h00);
        rd_chk("a_status_busy", 5'h10, 32'h09);
        i2c_busy = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("a_idle_enable", {31'd0, i2c_enable}, 32'd0);
        wr_chk("a_ctrl_off", 5'h00, 32'h00, 1'b0);

        // Overflow: fifth push into a 4-deep FIFO
        for (int i = 1; i <= 4; i++)
            wr_chk($sformatf("b_push%0d", i), 5'h08, 32'(i), 1'b0);
        wr_chk("b_push5", 5'h08, 32'h05, 1'b1);
        rd_chk("b_status_ovr", 5'h10, 32'h22);
        check("b_head", {24'd0, i2c_data_in}, 32'h01);
        check("b_irq_ovr", {31'd0, irq}, 32'd1);
        wr_chk("b_w1c", 5'h10, 32'h20, 1'b0);
        rd_chk("b_status_w1c", 5'h10, 32'h02);
        wr_chk("b_flush", 5'h00, 32'h08, 1'b0);
        rd_chk("b_status_flush", 5'h10, 32'h01);
        check("b_data_flush", {24'd0, i2c_data_in}, 32'h00);

        // Read mode: RX overrun, then NACK
        wr_chk("c_ctrl", 5'h00, 32'h11, 1'b0);
        @(posedge clk); #1;
        check("c_enable", {31'd0, i2c_enable}, 32'd1);
        check("c_rw", {31'd0, i2c_rw}, 32'd0);
        i2c_rx_valid = 1'b1; i2c_rx_data = 8'h11;
        @(posedge clk); #1;
        i2c_rx_data = 8'h22;
        @(posedge clk); #1;
        i2c_rx_valid = 1'b0;
        rd_chk("c_status_ovr", 5'h10, 32'h25);
        check("c_irq_rx", {31'd0, irq}, 32'd1);
        rd_chk("c_rxdata", 5'h0C, 32'h22);
        rd_chk("c_status_rxclr", 5'h10, 32'h21);
        wr_chk("c_w1c_ovr", 5'h10, 32'h20, 1'b0);
        rd_chk("c_status_clean", 5'h10, 32'h01);
        check("c_irq_clean", {31'd0, irq}, 32'd0);
        check("c_enable_run", {31'd0, i2c_enable}, 32'd1);
        i2c_nack = 1'b1;
        @(posedge clk); #1;
        i2c_nack = 1'b0;
        check("c_nack_enable", {31'd0, i2c_enable}, 32'd0);
        check("c_nack_irq", {31'd0, irq}, 32'd1);
        rd_chk("c_nack_ctrl", 5'h00, 32'h10);
        rd_chk("c_nack_status", 5'h10, 32'h11);
        wr_chk("c_w1c_nack", 5'h10, 32'h10, 1'b0);
        check("c_irq_after", {31'd0, irq}, 32'd0);
        wr_chk("c_ctrl_off", 5'h00, 32'h00, 1'b0);

        // Full FIFO with same-cycle pop and push
        for (int i = 0; i < 4; i++)
            wr_chk($sformatf("d_push%0d", i), 5'h08, 32'hA0 + 32'(i), 1'b0);
        wr_chk("d_ctrl", 5'h00, 32'h03, 1'b0);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h08; pwdata = 32'hA4;
        @(posedge clk); #1;
        check("d_run_head", {24'd0, i2c_data_in}, 32'hA0);
        penable = 1'b1; i2c_byte_done = 1'b1; #1;
        check("d_push_pop_err", {31'd0, pslverr}, 32'd0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; i2c_byte_done = 1'b0;
        rd_chk("d_status_full", 5'h10, 32'h02);
        check("d_order1", {24'd0, i2c_data_in}, 32'hA1);
        pulse_byte_done();
        check("d_order2", {24'd0, i2c_data_in}, 32'hA2);
        pulse_byte_done();
        check("d_order3", {24'd0, i2c_data_in}, 32'hA3);
        pulse_byte_done();
        check("d_order4", {24'd0, i2c_data_in}, 32'hA4);
        check("d_enable_last", {31'd0, i2c_enable}, 32'd1);
        pulse_byte_done();
        check("d_enable_end", {31'd0, i2c_enable}, 32'd0);
        rd_chk("d_status_end", 5'h10, 32'h01);
        wr_chk("d_ctrl_off", 5'h00, 32'h00, 1'b0);

        // Asynchronous reset mid-transfer
        wr_chk("e_ctrl", 5'h00, 32'h21, 1'b0);
        @(posedge clk); #1;
        check("e_enable_run", {31'd0, i2c_enable}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("e_enable_rst", {31'd0, i2c_enable}, 32'd0);
        check("e_irq_rst", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd_chk("e_ctrl_rst", 5'h00, 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
